// File: rtl/fifo_word_serializer_pkg.sv
// Shared types and the width-ratio helper for the FIFO word serializer.
package ser_pkg;

  typedef enum logic [0:0] {S_IDLE, S_SEND} ser_state_t;

  // Returns in_w/out_w, or 0 when the widths do not divide evenly.
  function automatic int ser_ratio(input int in_w, input int out_w);
    if (out_w <= 0 || in_w < out_w || (in_w % out_w) != 0) return 0;
    return in_w / out_w;
  endfunction

endpackage

// File: rtl/fifo_word_serializer.sv
// Pops wide words from a FIFO read port and streams them out as ratio narrow
// beats on a valid/ready interface, reloading on the last beat without a bubble.
module fifo_word_serializer
  import ser_pkg::*;
#(
  parameter int in_width  = 32,
  parameter int out_width = 8,
  parameter bit msb_first = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [in_width-1:0]  fifo_read_data,
  output logic                 fifo_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [out_width-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int ratio  = ser_ratio(in_width, out_width);
  localparam int beat_w = (ratio > 1) ? $clog2(ratio) : 1;
  localparam logic [beat_w-1:0] last_cnt = beat_w'(ratio - 1);

  if (ratio < 1) begin : g_bad_ratio
    $error("fifo_word_serializer: in_width must be a non-zero multiple of out_width");
  end

  ser_state_t          state, state_nxt;
  logic [in_width-1:0] shreg, shreg_shift;
  logic [beat_w-1:0]   beat_cnt;
  logic                take;

  assign take     = (state == S_SEND) & out_ready;
  assign out_last = (beat_cnt == last_cnt);
  assign busy     = out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (!fifo_empty) state_nxt = S_SEND;
      S_SEND: if (take && out_last && fifo_empty) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pop is gated by rst_n so a held reset never drains the FIFO.
  always_comb begin
    out_valid = (state == S_SEND);
    fifo_pop  = rst_n & ~fifo_empty & ((state == S_IDLE) | (take & out_last));
  end

  assign shreg_shift = msb_first ? (shreg << out_width) : (shreg >> out_width);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      beat_cnt <= '0;
    end else if (fifo_pop) begin
      shreg    <= fifo_read_data;
      beat_cnt <= '0;
    end else if (take) begin
      if (out_last) begin
        beat_cnt <= '0;
      end else begin
        shreg    <= shreg_shift;
        beat_cnt <= beat_cnt + beat_w'(1);
      end
    end
  end

  // The beat is always the aligned end of the shift register, so out_data
  // comes straight from flops with no path from out_ready.
  if (msb_first) begin : g_msb
    assign out_data = shreg[in_width-1 -: out_width];
  end else begin : g_lsb
    assign out_data = shreg[out_width-1:0];
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: queue-modelled FIFO feeding lsb-first,
// msb-first and ratio-1 builds, with a beat-stream scoreboard.
module tb_fifo_word_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_read_data = '0;
  logic        out_ready = 1'b0;
  logic        pop_l, pop_m, val_l, val_m, last_l, last_m, busy_l, busy_m;
  logic [7:0]  data_l, data_m;

  logic        empty1 = 1'b1;
  logic [7:0]  rd1 = '0;
  logic        ready1 = 1'b0;
  logic        pop1, val1, last1, busy1;
  logic [7:0]  data1;

  fifo_word_serializer #(.in_width(32), .out_width(8), .msb_first(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
    .fifo_pop(pop_l), .out_valid(val_l), .out_ready(out_ready), .out_data(data_l),
    .out_last(last_l), .busy(busy_l));

  fifo_word_serializer #(.in_width(32), .out_width(8), .msb_first(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
    .fifo_pop(pop_m), .out_valid(val_m), .out_ready(out_ready), .out_data(data_m),
    .out_last(last_m), .busy(busy_m));

  fifo_word_serializer #(.in_width(8), .out_width(8), .msb_first(1'b0)) u_r1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(empty1), .fifo_read_data(rd1),
    .fifo_pop(pop1), .out_valid(val1), .out_ready(ready1), .out_data(data1),
    .out_last(last1), .busy(busy1));

  typedef struct {
    bit          push;
    logic [31:0] w;
    bit          ev;
    logic [7:0]  dl;
    logic [7:0]  dm;
    bit          el;
    bit          ep;
  } vec_t;

  vec_t tbl[18];
  vec_t cur;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] q[$];
  logic [8:0]  exp_l[$], exp_m[$];
  logic [7:0]  q1[$], exp1[$];

  bit         p_pop, p_stall, p_last, p_pop1, p_stall1;
  logic [7:0] p_data, p_data_m, p_data1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input bit push, input logic [31:0] w, input bit ev,
                             input logic [7:0] dl, input logic [7:0] dm, input bit el, input bit ep);
    vec_t r;
    r.push = push; r.w = w; r.ev = ev; r.dl = dl; r.dm = dm; r.el = el; r.ep = ep;
    return r;
  endfunction

  // Model: each pushed word becomes four beats, sliced from either end.
  task automatic push_word(input logic [31:0] w);
    q.push_back(w);
    for (int b = 0; b < 4; b++) begin
      exp_l.push_back({b == 3, w[8*b +: 8]});
      exp_m.push_back({b == 3, w[31-8*b -: 8]});
    end
  endtask

  task automatic clear_hist();
    p_pop = 1'b0; p_stall = 1'b0; p_pop1 = 1'b0; p_stall1 = 1'b0;
  endtask

  // One clock: drive at negedge, sample #1 later, update the FIFO model after posedge.
  task automatic step(input bit push, input logic [31:0] w, input bit rdy,
                      input bit push1, input logic [7:0] w1, input bit rdy1, input bit use_vec);
    logic [8:0] e;
    logic [7:0] e1;
    bit popped, popped1;
    out_ready = rdy;
    ready1    = rdy1;
    fifo_empty     = (q.size() == 0);
    fifo_read_data = fifo_empty ? 32'h0 : q[0];
    empty1 = (q1.size() == 0);
    rd1    = empty1 ? 8'h0 : q1[0];
    #1;
    if (fifo_empty) check("pop_while_empty", 32'(pop_l), 32'd0);
    check("pop_msb_build", 32'(pop_m), 32'(pop_l));
    check("valid_msb_build", 32'(val_m), 32'(val_l));
    check("busy", 32'(busy_l), 32'(val_l));
    if (p_pop) check("pop_to_valid", 32'(val_l), 32'd1);
    if (p_stall) begin
      check("stall_valid", 32'(val_l), 32'd1);
      check("stall_data", 32'(data_l), 32'(p_data));
      check("stall_data_msb", 32'(data_m), 32'(p_data_m));
      check("stall_last", 32'(last_l), 32'(p_last));
    end
    if (val_l && rdy) begin
      if (exp_l.size() == 0) check("extra_beat", 32'd1, 32'd0);
      else begin
        e = exp_l.pop_front();
        check("beat_lsb", 32'({last_l, data_l}), 32'(e));
        e = exp_m.pop_front();
        check("beat_msb", 32'({last_m, data_m}), 32'(e));
      end
    end
    if (use_vec) begin
      check("vec_valid", 32'(val_l), 32'(cur.ev));
      check("vec_pop", 32'(pop_l), 32'(cur.ep));
      if (cur.ev) begin
        check("vec_data_lsb", 32'(data_l), 32'(cur.dl));
        check("vec_data_msb", 32'(data_m), 32'(cur.dm));
        check("vec_last", 32'(last_l), 32'(cur.el));
      end
    end
    if (empty1) check("r1_pop_while_empty", 32'(pop1), 32'd0);
    if (p_pop1) check("r1_pop_to_valid", 32'(val1), 32'd1);
    if (val1) check("r1_last_const", 32'(last1), 32'd1);
    if (p_stall1) check("r1_stall_data", 32'(data1), 32'(p_data1));
    if (val1 && rdy1) begin
      if (exp1.size() == 0) check("r1_extra_beat", 32'd1, 32'd0);
      else begin
        e1 = exp1.pop_front();
        check("r1_beat", 32'(data1), 32'(e1));
      end
    end
    popped = pop_l; popped1 = pop1;
    p_pop = pop_l; p_stall = val_l & ~rdy; p_data = data_l; p_data_m = data_m; p_last = last_l;
    p_pop1 = pop1; p_stall1 = val1 & ~rdy1; p_data1 = data1;
    @(posedge clk);
    if (popped && q.size() > 0) q.delete(0);
    if (popped1 && q1.size() > 0) q1.delete(0);
    if (push) push_word(w);
    if (push1) begin q1.push_back(w1); exp1.push_back(w1); end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 8'h0, 1'b1, 1'b0);
  endtask

  initial begin
    clear_hist();
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(val_l), 32'd0);
    check("rst_data", 32'(data_l), 32'd0);
    check("rst_last", 32'(last_l), 32'd0);
    check("rst_pop", 32'(pop_l), 32'd0);
    check("rst_r1_valid", 32'(val1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cycle tables: single word, then two back-to-back words.
    tbl[0]  = v(1'b1, 32'hA1B2C3D4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[1]  = v(1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tbl[2]  = v(1'b0, 32'h0, 1'b1, 8'hD4, 8'hA1, 1'b0, 1'b0);
    tbl[3]  = v(1'b0, 32'h0, 1'b1, 8'hC3, 8'hB2, 1'b0, 1'b0);
    tbl[4]  = v(1'b0, 32'h0, 1'b1, 8'hB2, 8'hC3, 1'b0, 1'b0);
    tbl[5]  = v(1'b0, 32'h0, 1'b1, 8'hA1, 8'hD4, 1'b1, 1'b0);
    tbl[6]  = v(1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[7]  = v(1'b1, 32'h11223344, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[8]  = v(1'b1, 32'h55667788, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tbl[9]  = v(1'b0, 32'h0, 1'b1, 8'h44, 8'h11, 1'b0, 1'b0);
    tbl[10] = v(1'b0, 32'h0, 1'b1, 8'h33, 8'h22, 1'b0, 1'b0);
    tbl[11] = v(1'b0, 32'h0, 1'b1, 8'h22, 8'h33, 1'b0, 1'b0);
    tbl[12] = v(1'b0, 32'h0, 1'b1, 8'h11, 8'h44, 1'b1, 1'b1);
    tbl[13] = v(1'b0, 32'h0, 1'b1, 8'h88, 8'h55, 1'b0, 1'b0);
    tbl[14] = v(1'b0, 32'h0, 1'b1, 8'h77, 8'h66, 1'b0, 1'b0);
    tbl[15] = v(1'b0, 32'h0, 1'b1, 8'h66, 8'h77, 1'b0, 1'b0);
    tbl[16] = v(1'b0, 32'h0, 1'b1, 8'h55, 8'h88, 1'b1, 1'b0);
    tbl[17] = v(1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      cur = tbl[i];
      step(cur.push, cur.w, 1'b1, 1'b0, 8'h0, 1'b1, 1'b1);
    end
    check("table_drained", 32'(exp_l.size()), 32'd0);

    // Backpressure: ready pattern 1,0,0 repeating over two words.
    step(1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 8'h0, 1'b1, 1'b0);
    step(1'b1, 32'h0BADBEEF, 1'b0, 1'b0, 8'h0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 32'h0, (i % 3) == 0, 1'b0, 8'h0, 1'b1, 1'b0);
    check("bp_all_taken", 32'(exp_l.size()), 32'd0);

    // Empty FIFO with a ready sink: no pops, no beats.
    idle(10);
    check("empty_idle_valid", 32'(val_l), 32'd0);

    // Ratio-1 build: one byte per cycle, every beat is last.
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    idle(3);
    check("r1_drained", 32'(exp1.size()), 32'd0);

    // Reset in the middle of a word, with the FIFO still holding another word.
    step(1'b1, 32'hA1B2C3D4, 1'b1, 1'b0, 8'h0, 1'b1, 1'b0);
    step(1'b1, 32'h11223344, 1'b1, 1'b0, 8'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 8'h0, 1'b1, 1'b0);
    check("pre_rst_busy", 32'(val_l), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(val_l), 32'd0);
    check("midrst_data", 32'(data_l), 32'd0);
    check("midrst_data_msb", 32'(data_m), 32'd0);
    check("midrst_last", 32'(last_l), 32'd0);
    check("midrst_pop", 32'(pop_l), 32'd0);
    q.delete(); exp_l.delete(); exp_m.delete(); q1.delete(); exp1.delete();
    clear_hist();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("post_rst_valid", 32'(val_l), 32'd0);

    // Random push / ready patterns against the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      step(q.size() < 4 && $urandom_range(0, 2) == 0, $urandom,
           $urandom_range(0, 3) != 0,
           q1.size() < 4 && $urandom_range(0, 1) == 1, 8'($urandom),
           $urandom_range(0, 3) != 0, 1'b0);
    end
    for (int i = 0; i < 200 && (exp_l.size() != 0 || exp1.size() != 0); i++) idle(1);
    check("rand_drained", 32'(exp_l.size()), 32'd0);
    check("rand_r1_drained", 32'(exp1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
